// File: rtl/input_map_pkg.sv
// Shared scancodes, joystick bit positions, key-register indices and direction helpers
// for the arcade input mapper.
package input_map_pkg;

   // Scancodes carry the E0-extended flag in bit 8.
   localparam logic [8:0] SC_P1_U   = 9'h175;
   localparam logic [8:0] SC_P1_D   = 9'h172;
   localparam logic [8:0] SC_P1_L   = 9'h16B;
   localparam logic [8:0] SC_P1_R   = 9'h174;
   localparam logic [8:0] SC_P1_F1  = 9'h014;
   localparam logic [8:0] SC_P1_F2  = 9'h011;
   localparam logic [8:0] SC_P1_ST  = 9'h016;
   localparam logic [8:0] SC_P1_ST2 = 9'h005;
   localparam logic [8:0] SC_P2_U   = 9'h02D;
   localparam logic [8:0] SC_P2_D   = 9'h02B;
   localparam logic [8:0] SC_P2_L   = 9'h023;
   localparam logic [8:0] SC_P2_R   = 9'h034;
   localparam logic [8:0] SC_P2_F1  = 9'h01C;
   localparam logic [8:0] SC_P2_F2  = 9'h01B;
   localparam logic [8:0] SC_P2_ST  = 9'h01E;
   localparam logic [8:0] SC_P2_ST2 = 9'h006;
   localparam logic [8:0] SC_COIN5  = 9'h02E;
   localparam logic [8:0] SC_COIN6  = 9'h036;

   localparam int JOY_R     = 0;
   localparam int JOY_L     = 1;
   localparam int JOY_D     = 2;
   localparam int JOY_U     = 3;
   localparam int JOY_FIRE1 = 4;
   localparam int JOY_FIRE2 = 5;
   localparam int JOY_START = 6;
   localparam int JOY_COIN  = 7;

   localparam int K_P1_U   = 0;
   localparam int K_P1_D   = 1;
   localparam int K_P1_L   = 2;
   localparam int K_P1_R   = 3;
   localparam int K_P1_F1  = 4;
   localparam int K_P1_F2  = 5;
   localparam int K_P1_ST  = 6;
   localparam int K_P1_ST2 = 7;
   localparam int K_P2_U   = 8;
   localparam int K_P2_D   = 9;
   localparam int K_P2_L   = 10;
   localparam int K_P2_R   = 11;
   localparam int K_P2_F1  = 12;
   localparam int K_P2_F2  = 13;
   localparam int K_P2_ST  = 14;
   localparam int K_P2_ST2 = 15;
   localparam int K_COIN5  = 16;
   localparam int K_COIN6  = 17;
   localparam int KEY_NUM  = 18;

   typedef enum logic [1:0] {
      ROT_NONE  = 2'd0,
      ROT_CW90  = 2'd1,
      ROT_180   = 2'd2,
      ROT_CCW90 = 2'd3
   } rot_e;

   typedef enum logic [1:0] {
      COIN_IDLE = 2'd0,
      COIN_HIGH = 2'd1,
      COIN_GAP  = 2'd2
   } coin_state_e;

   typedef struct packed {
      logic u;
      logic d;
      logic l;
      logic r;
   } dir_t;

   function automatic logic [KEY_NUM-1:0] key_onehot(input logic [8:0] code);
      logic [KEY_NUM-1:0] v;
      v = '0;
      case (code)
         SC_P1_U:   v[K_P1_U]   = 1'b1;
         SC_P1_D:   v[K_P1_D]   = 1'b1;
         SC_P1_L:   v[K_P1_L]   = 1'b1;
         SC_P1_R:   v[K_P1_R]   = 1'b1;
         SC_P1_F1:  v[K_P1_F1]  = 1'b1;
         SC_P1_F2:  v[K_P1_F2]  = 1'b1;
         SC_P1_ST:  v[K_P1_ST]  = 1'b1;
         SC_P1_ST2: v[K_P1_ST2] = 1'b1;
         SC_P2_U:   v[K_P2_U]   = 1'b1;
         SC_P2_D:   v[K_P2_D]   = 1'b1;
         SC_P2_L:   v[K_P2_L]   = 1'b1;
         SC_P2_R:   v[K_P2_R]   = 1'b1;
         SC_P2_F1:  v[K_P2_F1]  = 1'b1;
         SC_P2_F2:  v[K_P2_F2]  = 1'b1;
         SC_P2_ST:  v[K_P2_ST]  = 1'b1;
         SC_P2_ST2: v[K_P2_ST2] = 1'b1;
         SC_COIN5:  v[K_COIN5]  = 1'b1;
         SC_COIN6:  v[K_COIN6]  = 1'b1;
         default:   v = '0;
      endcase
      return v;
   endfunction

   function automatic dir_t rotate_dir(input dir_t din, input rot_e rot);
      dir_t o;
      case (rot)
         ROT_CW90: begin
            o.u = din.l; o.d = din.r; o.l = din.d; o.r = din.u;
         end
         ROT_180: begin
            o.u = din.d; o.d = din.u; o.l = din.r; o.r = din.l;
         end
         ROT_CCW90: begin
            o.u = din.r; o.d = din.l; o.l = din.u; o.r = din.d;
         end
         default: o = din;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/coin_pulse.sv
// Coin pulse generator: a request rising edge in IDLE gives COIN_HI CE ticks of coin,
// then COIN_LO ticks of lock-out; edges arriving during the pulse or lock-out are dropped.
module coin_pulse
   import input_map_pkg::*;
#(
   parameter int COIN_HI = 6,
   parameter int COIN_LO = 6
)
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_ce,
   input  logic i_req,
   output logic o_coin
);

   localparam int HI_EFF  = (COIN_HI < 1) ? 1 : COIN_HI;
   localparam int LO_EFF  = (COIN_LO < 1) ? 1 : COIN_LO;
   localparam int CNT_MAX = (HI_EFF > LO_EFF) ? HI_EFF : LO_EFF;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HI_EFF - 1);
   localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LO_EFF - 1);

   coin_state_e      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_req_d;
   logic             r_coin;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= COIN_IDLE;
         r_cnt   <= '0;
         r_req_d <= 1'b0;
         r_coin  <= 1'b0;
      end else begin
         r_req_d <= i_req;
         case (r_state)
            COIN_IDLE: begin
               if (i_req && !r_req_d) begin
                  r_state <= COIN_HIGH;
                  r_cnt   <= '0;
                  r_coin  <= 1'b1;
               end
            end
            COIN_HIGH: begin
               if (i_ce) begin
                  if (r_cnt == HI_LAST) begin
                     r_state <= COIN_GAP;
                     r_cnt   <= '0;
                     r_coin  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            COIN_GAP: begin
               if (i_ce) begin
                  if (r_cnt == LO_LAST) begin
                     r_state <= COIN_IDLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= COIN_IDLE;
               r_cnt   <= '0;
               r_coin  <= 1'b0;
            end
         endcase
      end
   end

   assign o_coin = r_coin;

endmodule

// File: rtl/arcade_input_mapper.sv
// PS/2 + joystick front-end: held-key decode, joystick merge, rotation, coin pulse; outputs one CLK
// after input. Optional per-player fire1 autofire is built only when INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper
   import input_map_pkg::*;
#(
   parameter int PLAYERS        = 2,
   parameter int COIN_HI        = 6,
   parameter int COIN_LO        = 6,
   parameter int AUTOFIRE_TICKS = 4
)
(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   CE,
   input  logic [64:0]            ps2_key,
   input  logic [16*PLAYERS-1:0]  joystick,
   input  logic                   merge_joy,
   input  logic [1:0]             rotate,
   input  logic [PLAYERS-1:0]     autofire,
   output logic [4*PLAYERS-1:0]   dir,
   output logic [2*PLAYERS-1:0]   fire,
   output logic [PLAYERS-1:0]     start,
   output logic                   coin
);

   logic               r_armed;
   logic               r_evt_tgl;
   logic [KEY_NUM-1:0] r_keys;
   logic [KEY_NUM-1:0] w_keys_nxt;
   logic [KEY_NUM-1:0] w_key_hit;
   logic               w_evt;
   logic               w_release;
   logic               w_ext;
   logic               w_valid;
   logic [8:0]         w_code;

   logic [7:0]         w_kb_p1;
   logic [7:0]         w_kb_p2;
   logic [7:0]         w_joy_or;
   logic [7:0]         w_raw [PLAYERS];
   logic [PLAYERS-1:0] w_fire1;
   logic               w_coin_req;
   logic               w_coin;
   logic               w_unused_joy;

   logic [4*PLAYERS-1:0] r_dir;
   logic [2*PLAYERS-1:0] r_fire;
   logic [PLAYERS-1:0]   r_start;

   // r_armed swallows the first cycle after reset so a toggle bit left set by a
   // pre-reset event is not replayed as a fresh make.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_armed   <= 1'b0;
         r_evt_tgl <= 1'b0;
         r_keys    <= '0;
      end else begin
         r_armed   <= 1'b1;
         r_evt_tgl <= ps2_key[64];
         r_keys    <= w_keys_nxt;
      end
   end

   assign w_evt     = r_armed & (ps2_key[64] ^ r_evt_tgl);
   assign w_release = (ps2_key[15:8] == 8'hF0);
   assign w_ext     = w_release ? (ps2_key[23:16] == 8'hE0) : (ps2_key[15:8] == 8'hE0);
   assign w_code    = {w_ext, ps2_key[7:0]};
   assign w_valid   = w_evt & (ps2_key[63:24] == 40'd0);
   assign w_key_hit = key_onehot(w_code);

   always_comb begin
      w_keys_nxt = r_keys;
      if (w_valid) begin
         w_keys_nxt = w_release ? (r_keys & ~w_key_hit) : (r_keys | w_key_hit);
      end
   end

   always_comb begin
      w_kb_p1            = '0;
      w_kb_p1[JOY_R]     = w_keys_nxt[K_P1_R];
      w_kb_p1[JOY_L]     = w_keys_nxt[K_P1_L];
      w_kb_p1[JOY_D]     = w_keys_nxt[K_P1_D];
      w_kb_p1[JOY_U]     = w_keys_nxt[K_P1_U];
      w_kb_p1[JOY_FIRE1] = w_keys_nxt[K_P1_F1];
      w_kb_p1[JOY_FIRE2] = w_keys_nxt[K_P1_F2];
      w_kb_p1[JOY_START] = w_keys_nxt[K_P1_ST] | w_keys_nxt[K_P1_ST2];
      w_kb_p2            = '0;
      w_kb_p2[JOY_R]     = w_keys_nxt[K_P2_R];
      w_kb_p2[JOY_L]     = w_keys_nxt[K_P2_L];
      w_kb_p2[JOY_D]     = w_keys_nxt[K_P2_D];
      w_kb_p2[JOY_U]     = w_keys_nxt[K_P2_U];
      w_kb_p2[JOY_FIRE1] = w_keys_nxt[K_P2_F1];
      w_kb_p2[JOY_FIRE2] = w_keys_nxt[K_P2_F2];
      w_kb_p2[JOY_START] = w_keys_nxt[K_P2_ST] | w_keys_nxt[K_P2_ST2];
   end

   always_comb begin
      w_joy_or     = '0;
      w_unused_joy = 1'b0;
      for (int n = 0; n < PLAYERS; n++) begin
         w_joy_or     = w_joy_or | joystick[16*n +: 8];
         w_unused_joy = w_unused_joy ^ (^joystick[16*n+8 +: 8]);
      end
      for (int n = 0; n < PLAYERS; n++) begin
         w_raw[n] = joystick[16*n +: 8];
         if (n == 0) begin
            w_raw[n] = w_raw[n] | w_kb_p1 | (merge_joy ? w_joy_or : 8'd0);
         end else if (n == 1) begin
            w_raw[n] = w_raw[n] | w_kb_p2;
         end
      end
   end

`ifdef INPUT_AUTOFIRE_EN
   localparam int AF_EFF = (AUTOFIRE_TICKS < 1) ? 1 : AUTOFIRE_TICKS;
   localparam int AF_W   = $clog2(AF_EFF + 1);
   localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_EFF - 1);

   logic [AF_W-1:0]    r_af_cnt [PLAYERS];
   logic [PLAYERS-1:0] r_af_phase;

   // Phase idles high so a fresh press fires immediately.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int n = 0; n < PLAYERS; n++) begin
            r_af_cnt[n] <= '0;
         end
         r_af_phase <= '1;
      end else begin
         for (int n = 0; n < PLAYERS; n++) begin
            if (!w_raw[n][JOY_FIRE1]) begin
               r_af_cnt[n]   <= '0;
               r_af_phase[n] <= 1'b1;
            end else if (CE) begin
               if (r_af_cnt[n] == AF_LAST) begin
                  r_af_cnt[n]   <= '0;
                  r_af_phase[n] <= ~r_af_phase[n];
               end else begin
                  r_af_cnt[n] <= r_af_cnt[n] + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      for (int n = 0; n < PLAYERS; n++) begin
         w_fire1[n] = w_raw[n][JOY_FIRE1] & (~autofire[n] | r_af_phase[n]);
      end
   end
`else
   logic w_unused_af;
   assign w_unused_af = ^autofire;

   always_comb begin
      for (int n = 0; n < PLAYERS; n++) begin
         w_fire1[n] = w_raw[n][JOY_FIRE1];
      end
   end
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_dir   <= '0;
         r_fire  <= '0;
         r_start <= '0;
      end else begin
         for (int n = 0; n < PLAYERS; n++) begin
            r_dir[4*n +: 4]  <= rotate_dir(dir_t'(w_raw[n][3:0]), rot_e'(rotate));
            r_fire[2*n +: 2] <= {w_raw[n][JOY_FIRE2], w_fire1[n]};
            r_start[n]       <= w_raw[n][JOY_START];
         end
      end
   end

   always_comb begin
      w_coin_req = w_keys_nxt[K_COIN5] | w_keys_nxt[K_COIN6];
      for (int n = 0; n < PLAYERS; n++) begin
         w_coin_req = w_coin_req | w_raw[n][JOY_COIN];
      end
   end

   coin_pulse #(
      .COIN_HI (COIN_HI),
      .COIN_LO (COIN_LO)
   ) u_coin_pulse (
      .i_clk  (CLK),
      .i_rst  (RESET),
      .i_ce   (CE),
      .i_req  (w_coin_req),
      .o_coin (w_coin)
   );

   assign dir   = r_dir;
   assign fire  = r_fire;
   assign start = r_start;
   assign coin  = w_coin;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: key decode, rotation, merge, coin timing, reset, autofire.
module tb_arcade_input_mapper;

   logic        clk;
   logic        rst;
   logic        ce;
   logic [64:0] ps2_key;
   logic [31:0] joystick;
   logic        merge_joy;
   logic [1:0]  rotate;
   logic [1:0]  autofire;
   logic [7:0]  dir;
   logic [3:0]  fire;
   logic [1:0]  start;
   logic        coin;

   int checks;
   int errors;

   arcade_input_mapper #(
      .PLAYERS        (2),
      .COIN_HI        (6),
      .COIN_LO        (6),
      .AUTOFIRE_TICKS (4)
   ) dut (
      .CLK       (clk),
      .RESET     (rst),
      .CE        (ce),
      .ps2_key   (ps2_key),
      .joystick  (joystick),
      .merge_joy (merge_joy),
      .rotate    (rotate),
      .autofire  (autofire),
      .dir       (dir),
      .fire      (fire),
      .start     (start),
      .coin      (coin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic ext, input logic rel, input logic [7:0] code);
      logic [63:0] v;
      v = {56'd0, code};
      if (ext && !rel) v[15:8] = 8'hE0;
      if (rel) v[15:8] = 8'hF0;
      if (ext && rel) v[23:16] = 8'hE0;
      ps2_key = {~ps2_key[64], v};
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; if (dir !== 8'h00) begin errors++; $display("FAIL reset_dir got %h want 00", dir); end
      checks++; if (fire !== 4'h0) begin errors++; $display("FAIL reset_fire got %h want 0", fire); end
      checks++; if (start !== 2'b00) begin errors++; $display("FAIL reset_start got %b want 00", start); end
      checks++; if (coin !== 1'b0) begin errors++; $display("FAIL reset_coin got %b want 0", coin); end
      rst = 1'b0;
      step();
      step();
   endtask

   task automatic test_key_dir();
      send_key(1'b1, 1'b0, 8'h75);
      checks++; if (dir !== 8'h08) begin errors++; $display("FAIL p1_up_make got %h want 08", dir); end
      send_key(1'b1, 1'b1, 8'h75);
      checks++; if (dir !== 8'h00) begin errors++; $display("FAIL p1_up_break got %h want 00", dir); end
      send_key(1'b0, 1'b0, 8'h75);
      checks++; if (dir !== 8'h00) begin errors++; $display("FAIL nonext_075 got %h want 00", dir); end
      send_key(1'b0, 1'b1, 8'h75);
      send_key(1'b0, 1'b0, 8'h2D);
      checks++; if (dir !== 8'h80) begin errors++; $display("FAIL p2_up got %h want 80", dir); end
      send_key(1'b0, 1'b0, 8'h05);
      checks++; if (start !== 2'b01) begin errors++; $display("FAIL p1_start_f1 got %b want 01", start); end
      send_key(1'b0, 1'b1, 8'h2D);
      send_key(1'b0, 1'b1, 8'h05);
      checks++; if ({dir, start} !== 10'd0) begin errors++; $display("FAIL keys_released got %h/%b want 00/00", dir, start); end
   endtask

   task automatic test_rotation();
      joystick = 32'h0000_0002;
      rotate = 2'd1;
      step();
      checks++; if (dir[3:0] !== 4'b1000) begin errors++; $display("FAIL rot_cw90 got %b want 1000", dir[3:0]); end
      rotate = 2'd3;
      step();
      checks++; if (dir[3:0] !== 4'b0100) begin errors++; $display("FAIL rot_ccw90 got %b want 0100", dir[3:0]); end
      rotate = 2'd2;
      step();
      checks++; if (dir[3:0] !== 4'b0001) begin errors++; $display("FAIL rot_180 got %b want 0001", dir[3:0]); end
      rotate = 2'd0;
      step();
      checks++; if (dir !== 8'h02) begin errors++; $display("FAIL rot_none got %h want 02", dir); end
      joystick = 32'h0;
      step();
   endtask

   task automatic test_merge();
      joystick = 32'h0010_0000;
      merge_joy = 1'b1;
      step();
      checks++; if (fire !== 4'b0101) begin errors++; $display("FAIL merge_on got %b want 0101", fire); end
      merge_joy = 1'b0;
      step();
      checks++; if (fire !== 4'b0100) begin errors++; $display("FAIL merge_off got %b want 0100", fire); end
      joystick = 32'h0;
      step();
   endtask

   task automatic test_back_to_back();
      send_key(1'b0, 1'b0, 8'h14);
      send_key(1'b0, 1'b0, 8'h11);
      checks++; if (fire !== 4'b0011) begin errors++; $display("FAIL ctrl_alt got %b want 0011", fire); end
      send_key(1'b0, 1'b0, 8'h1A);
      checks++; if (fire !== 4'b0011) begin errors++; $display("FAIL unmapped_key got %b want 0011", fire); end
      send_key(1'b0, 1'b1, 8'h14);
      checks++; if (fire !== 4'b0010) begin errors++; $display("FAIL ctrl_break got %b want 0010", fire); end
      send_key(1'b0, 1'b1, 8'h11);
      send_key(1'b0, 1'b1, 8'h1A);
   endtask

   task automatic test_ignored();
      ps2_key = {~ps2_key[64], 64'h0000_0001_0000_0014};
      step();
      step();
      checks++; if (fire !== 4'b0000) begin errors++; $display("FAIL long_code_ignored got %b want 0000", fire); end
   endtask

   task automatic test_coin();
      int hi;
      int rises;
      int seen;
      logic prev;
      send_key(1'b0, 1'b0, 8'h2E);
      checks++; if (coin !== 1'b1) begin errors++; $display("FAIL coin_key_rise got %b want 1", coin); end
      hi = coin ? 1 : 0;
      rises = hi;
      prev = coin;
      for (int i = 1; i < 100; i++) begin
         step();
         if (coin) hi++;
         if (coin && !prev) rises++;
         prev = coin;
      end
      checks++; if (hi != 6) begin errors++; $display("FAIL coin_width got %0d want 6", hi); end
      checks++; if (rises != 1) begin errors++; $display("FAIL coin_held_pulses got %0d want 1", rises); end
      send_key(1'b0, 1'b1, 8'h2E);
      step();
      ce = 1'b0;
      joystick[7] = 1'b1;
      step();
      for (int i = 0; i < 10; i++) step();
      checks++; if (coin !== 1'b1) begin errors++; $display("FAIL coin_hold_no_ce got %b want 1", coin); end
      ce = 1'b1;
      for (int i = 0; i < 5; i++) step();
      checks++; if (coin !== 1'b1) begin errors++; $display("FAIL coin_tick5 got %b want 1", coin); end
      step();
      checks++; if (coin !== 1'b0) begin errors++; $display("FAIL coin_tick6_fall got %b want 0", coin); end
      joystick[7] = 1'b0;
      step();
      step();
      joystick[7] = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (coin) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL coin_gap_edge got %0d high cycles want 0", seen); end
      joystick[7] = 1'b0;
      step();
      joystick[7] = 1'b1;
      step();
      checks++; if (coin !== 1'b1) begin errors++; $display("FAIL coin_after_gap got %b want 1", coin); end
      joystick[7] = 1'b0;
      for (int i = 0; i < 20; i++) step();
   endtask

   task automatic test_reset_held();
      send_key(1'b0, 1'b0, 8'h14);
      checks++; if (fire !== 4'b0001) begin errors++; $display("FAIL ctrl_before_reset got %b want 0001", fire); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if (fire !== 4'b0000) begin errors++; $display("FAIL fire_async_reset got %b want 0000", fire); end
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++; if (fire !== 4'b0000) begin errors++; $display("FAIL fire_after_reset got %b want 0000", fire); end
      send_key(1'b0, 1'b1, 8'h14);
   endtask

   task automatic test_autofire();
      logic exp;
      autofire = 2'b01;
      send_key(1'b0, 1'b0, 8'h14);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step();
`ifdef INPUT_AUTOFIRE_EN
         exp = ((i / 4) % 2) == 0;
`else
         exp = 1'b1;
`endif
         checks++; if (fire[0] !== exp) begin errors++; $display("FAIL autofire_t%0d got %b want %b", i, fire[0], exp); end
      end
      send_key(1'b0, 1'b1, 8'h14);
      checks++; if (fire[0] !== 1'b0) begin errors++; $display("FAIL autofire_release got %b want 0", fire[0]); end
      autofire = 2'b00;
      step();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      ce        = 1'b1;
      ps2_key   = '0;
      joystick  = '0;
      merge_joy = 1'b0;
      rotate    = 2'd0;
      autofire  = 2'b00;
      test_reset();
      test_key_dir();
      test_rotation();
      test_merge();
      test_back_to_back();
      test_ignored();
      test_coin();
      test_reset_held();
      test_autofire();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Generalised control front-end for single-board arcade cores: decodes PS/2 key events into per-player held-key state, merges with up to four hps_io joysticks, applies cabinet rotation to directions, and produces a timed, lock-out protected coin pulse. Sits between `hps_io` and the game core in `emu`. All outputs are active-high; the core-specific inversion into input registers stays in `emu`.

## Interface
- `PLAYERS`, 2, number of player channels, 1..4; keyboard maps players 1 and 2 only.
- `COIN_HI`, 6, CE ticks coin stays asserted.
- `COIN_LO`, 6, CE ticks of lock-out after the pulse before a new coin edge is accepted.
- `AUTOFIRE_TICKS`, 4, CE ticks per autofire half-period (used only with the macro).
- `CLK  in  1  system clock (clk_sys).`
- `RESET  in  1  asynchronous, active-high reset.`
- `CE  in  1  tick enable for coin/autofire timing (ce_6m divided as the core needs).`
- `ps2_key  in  65  hps_io key event; bit 64 toggles per event.`
- `joystick  in  16*PLAYERS  per player: [0]R [1]L [2]D [3]U [4]fire1 [5]fire2 [6]start [7]coin.`
- `merge_joy  in  1  1: OR of all joysticks drives player 1 (others still driven individually).`
- `rotate  in  2  0 none, 1 CW90, 2 180, 3 CCW90.`
- `autofire  in  PLAYERS  per-player autofire on fire1; ignored without the macro.`
- `dir  out  4*PLAYERS  per player {U,D,L,R} after rotation.`
- `fire  out  2*PLAYERS  per player {fire2,fire1}.`
- `start  out  PLAYERS  start buttons.`
- `coin  out  1  coin pulse.`

## Operation
- Event detect: register bit 64; an event exists in the cycle it differs from its registered copy.
- Decode: release if [15:8]==F0; extended if ([15:8]==E0 on make) or ([23:16]==E0 on break); [63:24]!=0 → event ignored (PrtScr/Pause).
- Key map (ext flag, code): P1 U/D/L/R = E075/E072/E06B/E074, fire1 014 (Ctrl), fire2 011 (Alt), start 016 ('1') or 005 (F1). P2 U/D/L/R = 02D/02B/023/034 (R/F/D/G), fire1 01C (A), fire2 01B (S), start 01E ('2') or 006 (F2). Coin: 02E ('5'), 036 ('6').
- Held state: make sets the key register, break clears it; unmapped codes no effect; multiple keys feeding one function are ORed.
- Raw player n = key state (n<2) OR joystick n; player 0 additionally ORs all joysticks when merge_joy=1.
- Rotation per player, output←input: 1: U←L, D←R, L←D, R←U. 2: U←D, D←U, L←R, R←L. 3: U←R, D←L, L←U, R←D. Buttons unrotated.
- Coin request = OR of coin keys and every joystick bit 7. FSM: IDLE → HIGH on request rising edge; HIGH counts COIN_HI CE ticks then → GAP; GAP counts COIN_LO ticks then → IDLE. coin=1 only in HIGH. Edges in HIGH/GAP discarded, not queued. Held request yields one pulse.

## Timing
- All outputs registered: one CLK from key event or joystick change to dir/fire/start; coin rises one CLK after the request edge.
- Reset: all key registers 0, dir/fire/start/coin 0, FSM IDLE, counters 0. Keys held across reset read released until next make.
- Counters advance only on CE; COIN_HI/COIN_LO of 0 treated as 1. Counter width $clog2(max+1).
- rotate/merge_joy changes apply on the next CLK; no glitch filtering.

## Configuration
- `INPUT_AUTOFIRE_EN` defined: with autofire[n]=1 and fire1 held, fire1 output starts high and toggles every AUTOFIRE_TICKS CE ticks; counter resets on release. Undefined: fire1 passes through, autofire port ignored, no counter logic generated.

## Structure
- Package `input_map_pkg`: scancode localparams, joystick bit indices, rotation enum, direction vector typedef.
- Sub-module `coin_pulse`: the IDLE/HIGH/GAP FSM with COIN_HI/COIN_LO parameters; instantiated once.

## Test plan
- Make E075 then break E075, rotate=0 → dir[P1].U 1 cycle after make, 0 1 cycle after break.
- rotate=1, joystick0[1] (L) → P1 U=1, other directions 0; rotate=3 same input → D=1.
- Key '5' held 100 ticks, COIN_HI=6, COIN_LO=6 → exactly one pulse of 6 CE ticks; second '5' edge at GAP tick 3 → no pulse; edge after GAP → new pulse.
- merge_joy=1, joystick1[4]=1 → fire[P1].fire1=1 and fire[P2].fire1=1; merge_joy=0 → only P2.
- ps2_key with [63:24]!=0 → no output change; RESET asserted while Ctrl held → fire outputs 0 immediately and after deassert.
- INPUT_AUTOFIRE_EN, AUTOFIRE_TICKS=4, autofire[0]=1, Ctrl held → fire1 high 4 ticks, low 4 ticks, repeating; release → 0 next CLK.
